// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and write-through stores onto a single
// main-memory command port; fills issue one read per cycle and collect returns in order.
module mem_arbiter #(
   parameter int MEM_LATENCY = 4,
   parameter int BLOCK_WORDS = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ic_miss,
   input  logic [15:0]                    ic_miss_addr,
   input  logic                           dc_miss,
   input  logic [15:0]                    dc_miss_addr,
   input  logic                           dc_wr,
   input  logic [15:0]                    dc_wr_addr,
   input  logic [15:0]                    dc_wr_data,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [15:0]                    mem_addr,
   output logic [15:0]                    mem_wdata,
   input  logic [15:0]                    mem_rdata,
   input  logic                           mem_valid,
   output logic                           ic_fill_we,
   output logic                           ic_fill_done,
   output logic                           dc_fill_we,
   output logic                           dc_fill_done,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic [15:0]                    fill_data,
   output logic                           dc_wr_ack,
   output logic                           busy
);

   localparam int IW = $clog2(BLOCK_WORDS);
   localparam int HW = 16 - IW - 1;
   localparam int CW = $clog2(BLOCK_WORDS + MEM_LATENCY + 1);
   localparam logic [CW-1:0] ISSUE_END = CW'(BLOCK_WORDS);
   localparam logic [CW-1:0] RET_START = CW'(MEM_LATENCY);
   localparam logic [CW-1:0] CYC_MAX   = CW'(BLOCK_WORDS + MEM_LATENCY);
   localparam logic [IW-1:0] LAST_WORD = IW'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      FILL_I = 2'd2,
      FILL_D = 2'd3
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cyc_cnt_reg;
   logic [IW-1:0] ret_cnt_reg;
   logic [HW-1:0] blk_hi_reg;
   logic [15:0]   wr_addr_reg;
   logic [15:0]   wr_data_reg;
   logic          in_fill;
   logic          ret_beat;
   logic          last_beat;
   logic          unused_addr_bits;

   // Byte-offset bits below the block boundary are dropped when a miss is latched.
   assign unused_addr_bits = ^{ic_miss_addr[IW:0], dc_miss_addr[IW:0]};

   assign in_fill   = (state_reg == FILL_I) || (state_reg == FILL_D);
   // No read of this fill can have returned before MEM_LATENCY cycles into the state.
   assign ret_beat  = in_fill && mem_valid && (cyc_cnt_reg >= RET_START);
   assign last_beat = ret_beat && (ret_cnt_reg == LAST_WORD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cyc_cnt_reg <= '0;
         ret_cnt_reg <= '0;
         blk_hi_reg  <= '0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE) begin
            cyc_cnt_reg <= '0;
            ret_cnt_reg <= '0;
            if (dc_wr) begin
               wr_addr_reg <= dc_wr_addr;
               wr_data_reg <= dc_wr_data;
            end else if (dc_miss) begin
               blk_hi_reg <= dc_miss_addr[15:IW+1];
            end else if (ic_miss) begin
               blk_hi_reg <= ic_miss_addr[15:IW+1];
            end
         end else if (in_fill) begin
            if (last_beat) begin
               cyc_cnt_reg <= '0;
               ret_cnt_reg <= '0;
            end else begin
               if (cyc_cnt_reg != CYC_MAX) begin
                  cyc_cnt_reg <= cyc_cnt_reg + CW'(1);
               end
               if (ret_beat) begin
                  ret_cnt_reg <= ret_cnt_reg + IW'(1);
               end
            end
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (dc_wr) begin
               state_next = WRITE;
            end else if (dc_miss) begin
               state_next = FILL_D;
            end else if (ic_miss) begin
               state_next = FILL_I;
            end
         end
         WRITE:          state_next = IDLE;
         FILL_I, FILL_D: if (last_beat) state_next = IDLE;
         default:        state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_en       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      ic_fill_we   = 1'b0;
      ic_fill_done = 1'b0;
      dc_fill_we   = 1'b0;
      dc_fill_done = 1'b0;
      fill_word    = '0;
      fill_data    = '0;
      dc_wr_ack    = 1'b0;
      busy         = (state_reg != IDLE);

      if (state_reg == WRITE) begin
         mem_en    = 1'b1;
         mem_wr    = 1'b1;
         mem_addr  = wr_addr_reg;
         mem_wdata = wr_data_reg;
         dc_wr_ack = 1'b1;
      end

      // Issue phase: the first BLOCK_WORDS cycles of a fill walk the block in word order.
      if (in_fill && (cyc_cnt_reg < ISSUE_END)) begin
         mem_en   = 1'b1;
         mem_addr = {blk_hi_reg, cyc_cnt_reg[IW-1:0], 1'b0};
      end

      if (ret_beat) begin
         fill_word = ret_cnt_reg;
         fill_data = mem_rdata;
         if (state_reg == FILL_I) begin
            ic_fill_we   = 1'b1;
            ic_fill_done = last_beat;
         end else begin
            dc_fill_we   = 1'b1;
            dc_fill_done = last_beat;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-accurate memory model plus a transaction log,
// checked against timelines derived from the arbitration rules.
module tb_mem_arbiter;

   localparam int BW  = 8;
   localparam int LAT = 4;
   localparam int IW  = $clog2(BW);
   localparam int OCC = BW + LAT;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ic_miss, dc_miss, dc_wr;
   logic [15:0]   ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
   logic          mem_en, mem_wr;
   logic [15:0]   mem_addr, mem_wdata;
   logic [15:0]   mem_rdata = 16'h0;
   logic          mem_valid = 1'b0;
   logic          ic_fill_we, ic_fill_done, dc_fill_we, dc_fill_done;
   logic [IW-1:0] fill_word;
   logic [15:0]   fill_data;
   logic          dc_wr_ack, busy;
   logic [55+IW:0] all_out;

   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  rst_mark = 0;
   int  overlap_cnt = 0;
   bit  spur = 1'b0;
   logic [15:0] blk_mask = 16'(2 * BW - 1);

   typedef struct { int cyc; logic [15:0] addr; } iss_rec_t;
   typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; logic ack; } wr_rec_t;
   typedef struct { int cyc; logic dc; logic [IW-1:0] word; logic [15:0] data; logic done; } beat_rec_t;

   iss_rec_t    iss_q[$];
   wr_rec_t     wr_q[$];
   beat_rec_t   beat_q[$];
   logic [15:0] iss_addr[int];

   mem_arbiter #(.MEM_LATENCY(LAT), .BLOCK_WORDS(BW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
      .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr),
      .dc_wr(dc_wr), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .ic_fill_we(ic_fill_we), .ic_fill_done(ic_fill_done),
      .dc_fill_we(dc_fill_we), .dc_fill_done(dc_fill_done),
      .fill_word(fill_word), .fill_data(fill_data),
      .dc_wr_ack(dc_wr_ack), .busy(busy)
   );

   assign all_out = {mem_en, mem_wr, mem_addr, mem_wdata, ic_fill_we, ic_fill_done,
                     dc_fill_we, dc_fill_done, fill_word, fill_data, dc_wr_ack, busy};

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return (a * 16'd40503) ^ 16'h3C5A;
   endfunction

   // Memory: a read seen in cycle k returns in cycle k+LAT; reads before a reset are lost.
   always @(posedge clk) begin
      int k;
      #1;
      k = cyc - LAT;
      mem_valid = 1'b0;
      mem_rdata = 16'h0;
      if (spur) begin
         mem_valid = 1'b1;
         mem_rdata = 16'hBEEF;
      end else if (k > rst_mark && iss_addr.exists(k)) begin
         mem_valid = 1'b1;
         mem_rdata = mem_fn(iss_addr[k]);
      end
   end

   always @(negedge clk) begin
      iss_rec_t  ir;
      wr_rec_t   wrec;
      beat_rec_t br;
      if (rst_n) begin
         if (mem_en && !mem_wr) begin
            iss_addr[cyc] = mem_addr;
            ir.cyc = cyc; ir.addr = mem_addr;
            iss_q.push_back(ir);
         end
         if (mem_en && mem_wr) begin
            wrec.cyc = cyc; wrec.addr = mem_addr; wrec.data = mem_wdata; wrec.ack = dc_wr_ack;
            wr_q.push_back(wrec);
         end
         if (ic_fill_we || dc_fill_we) begin
            br.cyc = cyc; br.dc = dc_fill_we; br.word = fill_word; br.data = fill_data;
            br.done = ic_fill_done | dc_fill_done;
            beat_q.push_back(br);
         end
         if ((ic_fill_we && dc_fill_we) || (ic_fill_done && !ic_fill_we) ||
             (dc_fill_done && !dc_fill_we) || (dc_wr_ack && !(mem_en && mem_wr)))
            overlap_cnt = overlap_cnt + 1;
      end
   end

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL idle_after_reset: got %h want 0", all_out);
      end
   endtask

   task automatic test_fill(input bit dc, input logic [15:0] addr, input int hold);
      int t0, i0, b0, o0;
      logic [15:0] base;
      base = addr & ~blk_mask;
      @(posedge clk); #1;
      t0 = cyc; i0 = iss_q.size(); b0 = beat_q.size(); o0 = overlap_cnt;
      if (dc) begin dc_miss = 1'b1; dc_miss_addr = addr; end
      else begin ic_miss = 1'b1; ic_miss_addr = addr; end
      for (int k = 1; k <= OCC + 1; k++) begin
         @(posedge clk); #1;
         if (k == hold) begin
            ic_miss = 1'b0; dc_miss = 1'b0;
            ic_miss_addr = 16'($urandom); dc_miss_addr = 16'($urandom);
         end
         @(negedge clk);
         checks++;
         if (busy !== (k <= OCC)) begin
            failures++;
            $display("FAIL fill_busy k=%0d: got %b want %b", k, busy, (k <= OCC));
         end
      end
      checks++;
      if (iss_q.size() - i0 != BW) begin
         failures++;
         $display("FAIL fill_issue_count: got %0d want %0d", iss_q.size() - i0, BW);
      end else begin
         for (int i = 0; i < BW; i++) begin
            checks++;
            if (iss_q[i0+i].cyc != t0 + 1 + i || iss_q[i0+i].addr !== base + 16'(2 * i)) begin
               failures++;
               $display("FAIL fill_issue %0d: got cyc %0d addr %h want cyc %0d addr %h", i,
                        iss_q[i0+i].cyc - t0, iss_q[i0+i].addr, 1 + i, base + 16'(2 * i));
            end
         end
      end
      checks++;
      if (beat_q.size() - b0 != BW) begin
         failures++;
         $display("FAIL fill_beat_count: got %0d want %0d", beat_q.size() - b0, BW);
      end else begin
         for (int i = 0; i < BW; i++) begin
            checks++;
            if (beat_q[b0+i].cyc != t0 + 1 + LAT + i || beat_q[b0+i].dc !== dc ||
                beat_q[b0+i].word !== IW'(i) || beat_q[b0+i].data !== mem_fn(base + 16'(2 * i)) ||
                beat_q[b0+i].done !== (i == BW - 1)) begin
               failures++;
               $display("FAIL fill_beat %0d: got cyc %0d dc %b word %0d data %h done %b want cyc %0d dc %b word %0d data %h done %b",
                        i, beat_q[b0+i].cyc - t0, beat_q[b0+i].dc, beat_q[b0+i].word, beat_q[b0+i].data,
                        beat_q[b0+i].done, 1 + LAT + i, dc, i, mem_fn(base + 16'(2 * i)), (i == BW - 1));
            end
         end
      end
      checks++;
      if (overlap_cnt != o0) begin
         failures++;
         $display("FAIL fill_illegal_strobes: got %0d want 0", overlap_cnt - o0);
      end
   endtask

   task automatic test_spurious_idle();
      int b0;
      b0 = beat_q.size();
      @(negedge clk); spur = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (all_out !== '0) begin
            failures++;
            $display("FAIL spurious_idle k=%0d: got %h want 0", k, all_out);
         end
      end
      spur = 1'b0;
      checks++;
      if (beat_q.size() != b0) begin
         failures++;
         $display("FAIL spurious_idle_beats: got %0d want 0", beat_q.size() - b0);
      end
   endtask

   task automatic test_write(input logic [15:0] addr, input logic [15:0] data);
      int t0, w0, b0, i0;
      @(posedge clk); #1;
      t0 = cyc; w0 = wr_q.size(); b0 = beat_q.size(); i0 = iss_q.size();
      dc_wr = 1'b1; dc_wr_addr = addr; dc_wr_data = data;
      @(negedge clk); spur = 1'b1;
      @(posedge clk); #1;
      dc_wr = 1'b0; dc_wr_addr = 16'($urandom); dc_wr_data = 16'($urandom);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || dc_wr_ack !== 1'b1 || ic_fill_we !== 1'b0 || dc_fill_we !== 1'b0) begin
         failures++;
         $display("FAIL write_cycle: got busy %b ack %b we %b%b want 1 1 00", busy, dc_wr_ack,
                  ic_fill_we, dc_fill_we);
      end
      @(negedge clk);
      spur = 1'b0;
      checks++;
      if (busy !== 1'b0 || dc_wr_ack !== 1'b0 || mem_en !== 1'b0) begin
         failures++;
         $display("FAIL write_return: got busy %b ack %b en %b want 0 0 0", busy, dc_wr_ack, mem_en);
      end
      checks++;
      if (wr_q.size() - w0 != 1) begin
         failures++;
         $display("FAIL write_count: got %0d want 1", wr_q.size() - w0);
      end else if (wr_q[w0].cyc != t0 + 1 || wr_q[w0].addr !== addr || wr_q[w0].data !== data ||
                   wr_q[w0].ack !== 1'b1) begin
         failures++;
         $display("FAIL write_cmd: got cyc %0d addr %h data %h ack %b want cyc 1 addr %h data %h ack 1",
                  wr_q[w0].cyc - t0, wr_q[w0].addr, wr_q[w0].data, wr_q[w0].ack, addr, data);
      end
      checks++;
      if (beat_q.size() != b0 || iss_q.size() != i0) begin
         failures++;
         $display("FAIL write_side_effects: got beats %0d reads %0d want 0 0",
                  beat_q.size() - b0, iss_q.size() - i0);
      end
   endtask

   task automatic test_priority();
      int t0, w0, b0, i0, o0, n;
      int start[2];
      logic [15:0] base[2];
      logic [15:0] wa, wd, da, ia;
      wa = 16'($urandom); wd = 16'($urandom); da = 16'($urandom); ia = 16'($urandom);
      @(posedge clk); #1;
      t0 = cyc; w0 = wr_q.size(); b0 = beat_q.size(); i0 = iss_q.size(); o0 = overlap_cnt;
      dc_wr = 1'b1; dc_wr_addr = wa; dc_wr_data = wd;
      dc_miss = 1'b1; dc_miss_addr = da; ic_miss = 1'b1; ic_miss_addr = ia;
      // WRITE, one idle cycle, FILL_D, one idle cycle, FILL_I.
      start[0] = 3; start[1] = 3 + OCC + 1;
      base[0] = da & ~blk_mask; base[1] = ia & ~blk_mask;
      n = start[1] + OCC;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (k == 1) dc_wr = 1'b0;
         if (k == start[0] + 1) dc_miss = 1'b0;
         if (k == start[1] + 1) ic_miss = 1'b0;
         @(negedge clk);
         checks++;
         if (busy !== !(k == 2 || k == start[0] + OCC || k == n)) begin
            failures++;
            $display("FAIL priority_busy k=%0d: got %b", k, busy);
         end
      end
      checks++;
      if (wr_q.size() - w0 != 1 || wr_q[w0].cyc != t0 + 1 || wr_q[w0].addr !== wa ||
          wr_q[w0].data !== wd || wr_q[w0].ack !== 1'b1) begin
         failures++;
         $display("FAIL priority_write: got count %0d want 1 at cycle 1 addr %h data %h",
                  wr_q.size() - w0, wa, wd);
      end
      checks++;
      if (iss_q.size() - i0 != 2 * BW || beat_q.size() - b0 != 2 * BW) begin
         failures++;
         $display("FAIL priority_counts: got reads %0d beats %0d want %0d %0d",
                  iss_q.size() - i0, beat_q.size() - b0, 2 * BW, 2 * BW);
      end else begin
         for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < BW; i++) begin
               checks++;
               if (iss_q[i0+f*BW+i].cyc != t0 + start[f] + i ||
                   iss_q[i0+f*BW+i].addr !== base[f] + 16'(2 * i) ||
                   beat_q[b0+f*BW+i].cyc != t0 + start[f] + LAT + i ||
                   beat_q[b0+f*BW+i].dc !== (f == 0) || beat_q[b0+f*BW+i].word !== IW'(i) ||
                   beat_q[b0+f*BW+i].done !== (i == BW - 1)) begin
                  failures++;
                  $display("FAIL priority_fill %0d beat %0d: got read cyc %0d addr %h beat cyc %0d dc %b want %0d %h %0d %b",
                           f, i, iss_q[i0+f*BW+i].cyc - t0, iss_q[i0+f*BW+i].addr,
                           beat_q[b0+f*BW+i].cyc - t0, beat_q[b0+f*BW+i].dc,
                           start[f] + i, base[f] + 16'(2 * i), start[f] + LAT + i, (f == 0));
               end
            end
         end
      end
      checks++;
      if (overlap_cnt != o0) begin
         failures++;
         $display("FAIL priority_illegal_strobes: got %0d want 0", overlap_cnt - o0);
      end
   endtask

   task automatic test_wait_during_fill();
      int t0, b0, o0, n;
      int start[2];
      logic [15:0] base[2];
      logic [15:0] da, ia;
      da = 16'($urandom); ia = 16'($urandom);
      @(posedge clk); #1;
      t0 = cyc; b0 = beat_q.size(); o0 = overlap_cnt;
      dc_miss = 1'b1; dc_miss_addr = da;
      start[0] = 1; start[1] = 1 + OCC + 1;
      base[0] = da & ~blk_mask; base[1] = ia & ~blk_mask;
      n = start[1] + OCC;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (k == 1) dc_miss = 1'b0;
         if (k == 3) begin ic_miss = 1'b1; ic_miss_addr = ia; end
         if (k == start[1] + 1) ic_miss = 1'b0;
         @(negedge clk);
         checks++;
         if (busy !== !(k == start[0] + OCC || k == n)) begin
            failures++;
            $display("FAIL wait_busy k=%0d: got %b", k, busy);
         end
      end
      checks++;
      if (beat_q.size() - b0 != 2 * BW) begin
         failures++;
         $display("FAIL wait_beat_count: got %0d want %0d", beat_q.size() - b0, 2 * BW);
      end else begin
         for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < BW; i++) begin
               checks++;
               if (beat_q[b0+f*BW+i].cyc != t0 + start[f] + LAT + i ||
                   beat_q[b0+f*BW+i].dc !== (f == 0) || beat_q[b0+f*BW+i].word !== IW'(i) ||
                   beat_q[b0+f*BW+i].data !== mem_fn(base[f] + 16'(2 * i)) ||
                   beat_q[b0+f*BW+i].done !== (i == BW - 1)) begin
                  failures++;
                  $display("FAIL wait_fill %0d beat %0d: got cyc %0d dc %b word %0d data %h want cyc %0d dc %b word %0d data %h",
                           f, i, beat_q[b0+f*BW+i].cyc - t0, beat_q[b0+f*BW+i].dc,
                           beat_q[b0+f*BW+i].word, beat_q[b0+f*BW+i].data,
                           start[f] + LAT + i, (f == 0), i, mem_fn(base[f] + 16'(2 * i)));
               end
            end
         end
      end
      checks++;
      if (overlap_cnt != o0) begin
         failures++;
         $display("FAIL wait_illegal_strobes: got %0d want 0", overlap_cnt - o0);
      end
   endtask

   task automatic test_reset_mid_fill();
      int b0;
      b0 = beat_q.size();
      @(posedge clk); #1;
      dc_miss = 1'b1; dc_miss_addr = 16'($urandom);
      for (int k = 1; k <= 1 + LAT + 3; k++) begin
         @(posedge clk); #1;
         if (k == 1) dc_miss = 1'b0;
      end
      checks++;
      if (dc_fill_we !== 1'b1 || fill_word !== IW'(3)) begin
         failures++;
         $display("FAIL reset_mid_beat3: got we %b word %0d want 1 3", dc_fill_we, fill_word);
      end
      #2;
      rst_n = 1'b0;
      rst_mark = cyc;
      #1;
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL reset_async: got %h want 0", all_out);
      end
      @(posedge clk); #1;
      checks++;
      if (all_out !== '0) begin
         failures++;
         $display("FAIL reset_held: got %h want 0", all_out);
      end
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (all_out !== '0 || beat_q.size() - b0 != 3) begin
         failures++;
         $display("FAIL reset_release: got out %h beats %0d want 0 3", all_out, beat_q.size() - b0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ic_miss = 1'b0; dc_miss = 1'b0; dc_wr = 1'b0;
      ic_miss_addr = 16'h0; dc_miss_addr = 16'h0; dc_wr_addr = 16'h0; dc_wr_data = 16'h0;
      repeat (3) @(posedge clk);
      test_reset();
      test_fill(1'b1, 16'h1236, 1);
      test_spurious_idle();
      test_write(16'($urandom), 16'($urandom));
      test_fill(1'b0, 16'($urandom), 3);
      for (int r = 0; r < 4; r++) begin
         test_fill(1'($urandom_range(1, 0)), 16'($urandom), int'($urandom_range(4, 1)));
         test_write(16'($urandom), 16'($urandom));
      end
      test_priority();
      test_wait_during_fill();
      test_reset_mid_fill();
      test_fill(1'b0, 16'($urandom), 1);
      test_fill(1'b1, 16'($urandom), 2);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 4, cycles from a read issue (mem_en=1, mem_wr=0) to its mem_valid.
REQ-002 Parameter BLOCK_WORDS, default 8, 16-bit words per cache block; power of two.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ic_miss  in  1  I-cache block fill request; ic_miss_addr  in  16  missing byte address.
REQ-006 dc_miss  in  1  D-cache block fill request; dc_miss_addr  in  16  missing byte address.
REQ-007 dc_wr  in  1  write-through store request; dc_wr_addr  in  16 and dc_wr_data  in  16 give address and data.
REQ-008 mem_en  out  1, mem_wr  out  1, mem_addr  out  16, mem_wdata  out  16: main-memory command port, one command per cycle.
REQ-009 mem_rdata  in  16, mem_valid  in  1: read return port.
REQ-010 ic_fill_we  out  1, ic_fill_done  out  1; dc_fill_we  out  1, dc_fill_done  out  1.
REQ-011 fill_word  out  log2(BLOCK_WORDS)  word index of current fill beat; fill_data  out  16  equals mem_rdata.
REQ-012 dc_wr_ack  out  1  one-cycle store-complete pulse; busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states IDLE, WRITE, FILL_I, FILL_D; exactly one active.
REQ-014 In IDLE, priority is dc_wr > dc_miss > ic_miss; the winner is latched (address/data) and its state is entered on the next edge.
REQ-015 Requests not granted remain pending only while the requester holds them high; the arbiter stores no request queue.
REQ-016 WRITE lasts exactly one cycle: mem_en=1, mem_wr=1, mem_addr=latched dc_wr_addr, mem_wdata=latched dc_wr_data, dc_wr_ack=1; next state IDLE.
REQ-017 FILL_x issue phase: in the first BLOCK_WORDS cycles of the state, mem_en=1, mem_wr=0, mem_addr={latched_addr[15:log2(BLOCK_WORDS)+1], issue_cnt, 1'b0}, issue_cnt counting 0..BLOCK_WORDS-1; mem_en=0 afterwards.
REQ-018 Fill return: each mem_valid cycle in FILL_x asserts the matching fill_we, fill_word=ret_cnt, fill_data=mem_rdata, then ret_cnt increments.
REQ-019 On the beat with ret_cnt=BLOCK_WORDS-1, the matching fill_done is asserted in the same cycle as fill_we; next state IDLE; counters cleared.
REQ-020 Total fill occupancy is BLOCK_WORDS+MEM_LATENCY cycles (12 for defaults), request-to-IDLE-return 13 cycles.
REQ-021 A fill always runs to completion; deassertion of the miss input mid-fill is ignored.
REQ-022 Requests arriving while busy=1 wait; the new arbitration occurs only in IDLE, so IDLE lasts at least one cycle between operations.
REQ-023 mem_valid in IDLE or WRITE is ignored: no fill_we, no counter change.
REQ-024 Block alignment: low address bits below the block boundary from the miss address are discarded; first issued address is block base.
REQ-025 Only the granted cache's fill_we/fill_done may assert; the other remains 0.
REQ-026 When inactive, mem_addr, mem_wdata, fill_word drive 0.

Reset
REQ-027 rst_n=0 immediately forces IDLE, clears issue_cnt, ret_cnt, latched address/data; all outputs 0, including mid-fill or mid-write.
REQ-028 After rst_n release, first arbitration happens on the first rising edge with rst_n=1.

Verification
REQ-029 dc_miss=1, dc_miss_addr=0x1236 from IDLE -> mem_addr 0x1230,0x1232,...,0x123E on cycles 1-8; dc_fill_we cycles 5-12 with fill_word 0-7; dc_fill_done cycle 12; busy low cycle 13.
REQ-030 dc_wr, dc_miss, ic_miss asserted together -> WRITE first (dc_wr_ack one cycle, mem_wr=1), then FILL_D, then FILL_I; no overlap of fill_we signals.
REQ-031 ic_miss during FILL_D -> ic waits; FILL_I begins one cycle after IDLE re-entry; ic_fill_done after 12 more cycles.
REQ-032 rst_n pulsed low at fill beat 3 -> outputs 0 asynchronously, busy=0; fresh request afterward restarts from word 0.
REQ-033 Spurious mem_valid=1 in IDLE with mem_rdata=0xBEEF -> no fill_we, counters unchanged.
REQ-034 ic_miss dropped after cycle 2 of FILL_I -> all 8 beats and ic_fill_done still produced.
